// File: rtl/dat_mem_arbiter.sv
// Arbiter sharing the single-port DAT RAM between the CSR window and the controller command path.
// Build option: define I3C_DAT_ARB_RR_EN for round-robin IDLE arbitration (default: controller-first with CSR starvation override).
module dat_mem_arbiter #(
    parameter int DEPTH        = 128,
    parameter int WIDTH        = 64,
    parameter int AW           = $clog2(DEPTH) + 1,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     csr_req_i,
    input  logic                     csr_write_i,
    input  logic [AW-1:0]            csr_addr_i,
    input  logic [WIDTH-1:0]         csr_wdata_i,
    input  logic [WIDTH-1:0]         csr_wmask_i,
    output logic                     csr_gnt_o,
    output logic                     csr_rvalid_o,
    output logic [WIDTH-1:0]         csr_rdata_o,
    output logic                     csr_err_o,

    input  logic                     ctl_req_i,
    input  logic                     ctl_write_i,
    input  logic [AW-1:0]            ctl_addr_i,
    input  logic [WIDTH-1:0]         ctl_wdata_i,
    input  logic [WIDTH-1:0]         ctl_wmask_i,
    input  logic                     ctl_lock_i,
    output logic                     ctl_gnt_o,
    output logic                     ctl_rvalid_o,
    output logic [WIDTH-1:0]         ctl_rdata_o,
    output logic                     ctl_err_o,

    output logic                     lock_timeout_o,

    output logic                     mem_req_o,
    output logic                     mem_write_o,
    output logic [$clog2(DEPTH)-1:0] mem_addr_o,
    output logic [WIDTH-1:0]         mem_wdata_o,
    output logic [WIDTH-1:0]         mem_wmask_o,
    input  logic [WIDTH-1:0]         mem_rdata_i
);

    localparam int MW = $clog2(DEPTH);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q;
    logic [LW-1:0]   lock_cnt_q;
    logic            lock_block_q;

    logic            csr_win;
    logic            ctl_win;
    logic            any_gnt;
    logic            csr_in_range;
    logic            ctl_in_range;
    logic            sel_in_range;
    logic            sel_write;
    logic [MW-1:0]   sel_idx;
    logic [WIDTH-1:0] sel_wdata;
    logic [WIDTH-1:0] sel_wmask;

    logic            rsp_vld_p1;
    logic            rsp_err_p1;
    logic            rd_owner_q;

`ifdef I3C_DAT_ARB_RR_EN
    logic            rr_last_ctl_q;
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0]   starve_cnt_q;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == STARVE_MAX) ? v : v + SW'(1);
    endfunction
`endif

    assign csr_in_range = (csr_addr_i < AW'(DEPTH));
    assign ctl_in_range = (ctl_addr_i < AW'(DEPTH));

    // Request stage: combinational grant, gated off while reset is asserted
    always_comb begin
        csr_win = 1'b0;
        ctl_win = 1'b0;
        if (rst_ni) begin
            if (state_q == LOCKED) begin
                ctl_win = ctl_req_i;
            end else begin
`ifdef I3C_DAT_ARB_RR_EN
                if (csr_req_i && ctl_req_i) begin
                    csr_win = rr_last_ctl_q;
                    ctl_win = !rr_last_ctl_q;
                end else begin
                    csr_win = csr_req_i;
                    ctl_win = ctl_req_i;
                end
`else
                if (csr_req_i && (!ctl_req_i || starve_cnt_q == STARVE_MAX)) begin
                    csr_win = 1'b1;
                end else begin
                    ctl_win = ctl_req_i;
                end
`endif
            end
        end
    end

    assign any_gnt      = csr_win | ctl_win;
    assign sel_in_range = ctl_win ? ctl_in_range : csr_in_range;
    assign sel_write    = ctl_win ? ctl_write_i : csr_write_i;
    assign sel_idx      = ctl_win ? ctl_addr_i[MW-1:0] : csr_addr_i[MW-1:0];
    assign sel_wdata    = ctl_win ? ctl_wdata_i : csr_wdata_i;
    assign sel_wmask    = ctl_win ? ctl_wmask_i : csr_wmask_i;

    assign csr_gnt_o   = csr_win;
    assign ctl_gnt_o   = ctl_win;

    // Out-of-range requests are accepted but never reach the RAM
    assign mem_req_o   = any_gnt & sel_in_range;
    assign mem_write_o = mem_req_o & sel_write;
    assign mem_addr_o  = mem_req_o ? sel_idx : '0;
    assign mem_wdata_o = mem_req_o ? sel_wdata : '0;
    assign mem_wmask_o = mem_req_o ? sel_wmask : '0;

`ifdef I3C_DAT_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_ctl_q <= 1'b0;
        end else if (any_gnt) begin
            rr_last_ctl_q <= ctl_win;
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (!csr_req_i || csr_win) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= sat_inc(starve_cnt_q);
        end
    end
`endif

    // Lock FSM; lock_block_q suppresses relocking after a timeout until ctl_lock_i falls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            lock_cnt_q     <= '0;
            lock_block_q   <= 1'b0;
            lock_timeout_o <= 1'b0;
        end else begin
            lock_timeout_o <= 1'b0;
            if (!ctl_lock_i) begin
                lock_block_q <= 1'b0;
            end
            if (state_q == IDLE) begin
                if (ctl_win && ctl_lock_i && !lock_block_q) begin
                    state_q    <= LOCKED;
                    lock_cnt_q <= '0;
                end
            end else begin
                lock_cnt_q <= lock_cnt_q + LW'(1);
                if (!ctl_lock_i) begin
                    state_q <= IDLE;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_q        <= IDLE;
                    lock_timeout_o <= 1'b1;
                    lock_block_q   <= 1'b1;
                end
            end
        end
    end

    // Response stage: one cycle after grant, aligned with the RAM read latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_p1 <= 1'b0;
            rsp_err_p1 <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rsp_vld_p1 <= any_gnt & (!sel_in_range | !sel_write);
            rsp_err_p1 <= any_gnt & !sel_in_range;
            rd_owner_q <= ctl_win;
        end
    end

    assign csr_rvalid_o = rsp_vld_p1 & !rd_owner_q;
    assign ctl_rvalid_o = rsp_vld_p1 & rd_owner_q;
    assign csr_err_o    = csr_rvalid_o & rsp_err_p1;
    assign ctl_err_o    = ctl_rvalid_o & rsp_err_p1;
    assign csr_rdata_o  = (csr_rvalid_o && !rsp_err_p1) ? mem_rdata_i : '0;
    assign ctl_rdata_o  = (ctl_rvalid_o && !rsp_err_p1) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Scoreboard bench for dat_mem_arbiter: directed stimulus, expected responses queued and checked by a monitor.
module tb_dat_mem_arbiter;

    localparam int DEPTH = 128;
    localparam int WIDTH = 64;
    localparam int AW    = 8;
    localparam logic [63:0] ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LO   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] D3   = 64'hDEAD_BEEF_0000_0003;
    localparam logic [63:0] D3B  = 64'hDEAD_BEEF_FFFF_FFFF;
    localparam logic [63:0] D5   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D127 = 64'hA5A5_5A5A_0F0F_F0F0;

    logic             clk_i;
    logic             rst_ni;
    logic             csr_req_i, csr_write_i, csr_gnt_o, csr_rvalid_o, csr_err_o;
    logic [AW-1:0]    csr_addr_i;
    logic [WIDTH-1:0] csr_wdata_i, csr_wmask_i, csr_rdata_o;
    logic             ctl_req_i, ctl_write_i, ctl_lock_i, ctl_gnt_o, ctl_rvalid_o, ctl_err_o;
    logic [AW-1:0]    ctl_addr_i;
    logic [WIDTH-1:0] ctl_wdata_i, ctl_wmask_i, ctl_rdata_o;
    logic             lock_timeout_o, mem_req_o, mem_write_o;
    logic [6:0]       mem_addr_o;
    logic [WIDTH-1:0] mem_wdata_o, mem_wmask_o, mem_rdata_i;

    dat_mem_arbiter #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .STARVE_LIMIT(4), .LOCK_MAX(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .csr_req_i(csr_req_i), .csr_write_i(csr_write_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_wmask_i(csr_wmask_i), .csr_gnt_o(csr_gnt_o),
        .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
        .ctl_req_i(ctl_req_i), .ctl_write_i(ctl_write_i), .ctl_addr_i(ctl_addr_i),
        .ctl_wdata_i(ctl_wdata_i), .ctl_wmask_i(ctl_wmask_i), .ctl_lock_i(ctl_lock_i),
        .ctl_gnt_o(ctl_gnt_o), .ctl_rvalid_o(ctl_rvalid_o), .ctl_rdata_o(ctl_rdata_o),
        .ctl_err_o(ctl_err_o), .lock_timeout_o(lock_timeout_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural 1-cycle-latency single-port RAM with bit write mask
    logic [63:0] ram [DEPTH];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_write_o)
                ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
            else
                mem_rdata_i <= ram[mem_addr_o];
        end
    end

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          ctl;
        bit          err;
        logic [63:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input bit ctl, input bit err, input logic [63:0] data);
        rsp_t e;
        e.ctl  = ctl;
        e.err  = err;
        e.data = data;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: pops the oldest expected response whenever the DUT presents one
    always @(negedge clk_i) begin
        rsp_t e;
        if (csr_rvalid_o || ctl_rvalid_o) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rvalid: csr_rvalid=%b ctl_rvalid=%b, required no response (cycle %0d)",
                         csr_rvalid_o, ctl_rvalid_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_owner_ctl", ctl_rvalid_o, e.ctl);
                chk("rsp_other_rvalid", e.ctl ? csr_rvalid_o : ctl_rvalid_o, 0);
                chk("rsp_err", e.ctl ? ctl_err_o : csr_err_o, e.err);
                chk("rsp_rdata", e.ctl ? ctl_rdata_o : csr_rdata_o, e.data);
                chk("rsp_other_rdata", e.ctl ? csr_rdata_o : ctl_rdata_o, 0);
            end
        end else if (sb.size() != 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_rvalid: no response, required one at cycle %0d (now %0d)", e.due, cyc);
        end
    end

    task automatic idle_all();
        csr_req_i = 0; csr_write_i = 0; csr_addr_i = '0; csr_wdata_i = '0; csr_wmask_i = '0;
        ctl_req_i = 0; ctl_write_i = 0; ctl_addr_i = '0; ctl_wdata_i = '0; ctl_wmask_i = '0;
        ctl_lock_i = 0;
    endtask

    task automatic csr_set(input bit req, input bit wr, input int addr, input logic [63:0] d, input logic [63:0] m);
        csr_req_i = req; csr_write_i = wr; csr_addr_i = AW'(addr); csr_wdata_i = d; csr_wmask_i = m;
    endtask

    task automatic ctl_set(input bit req, input bit wr, input int addr, input logic [63:0] d, input logic [63:0] m,
                           input bit lock);
        ctl_req_i = req; ctl_write_i = wr; ctl_addr_i = AW'(addr); ctl_wdata_i = d; ctl_wmask_i = m;
        ctl_lock_i = lock;
    endtask

    task automatic cyc_begin();
        @(posedge clk_i);
        #1;
        idle_all();
    endtask

    task automatic chk_gnt(input bit exp_csr, input bit exp_ctl);
        chk("csr_gnt", csr_gnt_o, exp_csr);
        chk("ctl_gnt", ctl_gnt_o, exp_ctl);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_csr_gnt", csr_gnt_o, 0);
        chk("rst_ctl_gnt", ctl_gnt_o, 0);
        chk("rst_csr_rvalid", csr_rvalid_o, 0);
        chk("rst_ctl_rvalid", ctl_rvalid_o, 0);
        chk("rst_csr_err", csr_err_o, 0);
        chk("rst_ctl_err", ctl_err_o, 0);
        chk("rst_csr_rdata", csr_rdata_o, 0);
        chk("rst_ctl_rdata", ctl_rdata_o, 0);
        chk("rst_lock_timeout", lock_timeout_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", 64'(mem_addr_o), 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_wmask", mem_wmask_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_csr;

        rst_ni = 1'b0;
        idle_all();
        repeat (2) @(posedge clk_i);
        #1;
        csr_set(1, 1, 5, D5, ALL);
        ctl_set(1, 1, 3, D3, ALL, 1);
        @(negedge clk_i);
        chk_reset_outputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle_all();

        // Basic writes and back-to-back reads
        cyc_begin(); ctl_set(1, 1, 3, D3, ALL, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        chk("wr3_mem_req", mem_req_o, 1);
        chk("wr3_mem_write", mem_write_o, 1);
        chk("wr3_mem_addr", 64'(mem_addr_o), 3);
        chk("wr3_mem_wdata", mem_wdata_o, D3);

        cyc_begin(); csr_set(1, 1, 5, D5, ALL);
        @(negedge clk_i);
        chk_gnt(1, 0);
        chk("wr5_mem_req", mem_req_o, 1);
        chk("wr5_mem_write", mem_write_o, 1);
        chk("wr5_mem_addr", 64'(mem_addr_o), 5);

        cyc_begin(); ctl_set(1, 0, 3, '0, '0, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        chk("rd3_mem_req", mem_req_o, 1);
        chk("rd3_mem_write", mem_write_o, 0);
        expect_rsp(1, 0, D3);

        cyc_begin(); csr_set(1, 0, 5, '0, '0);
        @(negedge clk_i);
        chk_gnt(1, 0);
        chk("rd5_mem_req", mem_req_o, 1);
        chk("rd5_mem_addr", 64'(mem_addr_o), 5);
        expect_rsp(0, 0, D5);

        cyc_begin();
        @(negedge clk_i);
        chk_gnt(0, 0);
        chk("idle_mem_req", mem_req_o, 0);

        // Contention: both requesters hold reads every cycle
        for (int i = 0; i < 10; i++) begin
            cyc_begin(); csr_set(1, 0, 5, '0, '0); ctl_set(1, 0, 3, '0, '0, 0);
            @(negedge clk_i);
`ifdef I3C_DAT_ARB_RR_EN
            exp_csr = (i % 2 == 1);
`else
            exp_csr = (i % 5 == 4);
`endif
            chk_gnt(exp_csr, !exp_csr);
            chk("prio_mem_req", mem_req_o, 1);
            expect_rsp(!exp_csr, 0, exp_csr ? D5 : D3);
        end
        cyc_begin();

        // Locked read-modify-write with the CSR pending throughout
        cyc_begin(); csr_set(1, 0, 5, '0, '0); ctl_set(1, 0, 3, '0, '0, 1);
        @(negedge clk_i);
        chk_gnt(0, 1);
        expect_rsp(1, 0, D3);
        cyc_begin(); csr_set(1, 0, 5, '0, '0); ctl_set(1, 1, 3, LO, LO, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        chk("rmw_lock_timeout", lock_timeout_o, 0);
        cyc_begin(); csr_set(1, 0, 5, '0, '0);
        @(negedge clk_i);
        chk_gnt(1, 0);
        chk("rmw_lock_timeout", lock_timeout_o, 0);
        expect_rsp(0, 0, D5);
        cyc_begin();
        @(negedge clk_i);
        chk("rmw_lock_timeout", lock_timeout_o, 0);

        // Lock held for 20 cycles: forced release after 8 locked cycles, no relock
        for (int k = 0; k < 20; k++) begin
            cyc_begin(); csr_set(1, 0, 5, '0, '0); ctl_set(1, 0, 3, '0, '0, 1);
            @(negedge clk_i);
`ifdef I3C_DAT_ARB_RR_EN
            exp_csr = (k >= 9) && (k % 2 == 1);
`else
            exp_csr = (k >= 9) && ((k - 9) % 5 == 0);
`endif
            chk_gnt(exp_csr, !exp_csr);
            chk("to_lock_timeout", lock_timeout_o, (k == 9) ? 1 : 0);
            expect_rsp(!exp_csr, 0, exp_csr ? D5 : D3B);
        end
        cyc_begin();
        @(negedge clk_i);
        chk_gnt(0, 0);
        chk("to_lock_timeout_after", lock_timeout_o, 0);

        // Relock is possible once ctl_lock_i has fallen
        cyc_begin(); csr_set(1, 0, 5, '0, '0); ctl_set(1, 0, 3, '0, '0, 1);
        @(negedge clk_i);
        chk_gnt(0, 1);
        expect_rsp(1, 0, D3B);
        cyc_begin(); csr_set(1, 0, 5, '0, '0);
        @(negedge clk_i);
        chk_gnt(0, 0);
        cyc_begin(); csr_set(1, 0, 5, '0, '0);
        @(negedge clk_i);
        chk_gnt(1, 0);
        expect_rsp(0, 0, D5);
        cyc_begin();

        // Address range boundaries
        cyc_begin(); csr_set(1, 0, 200, '0, '0);
        @(negedge clk_i);
        chk_gnt(1, 0);
        chk("oor_rd_mem_req", mem_req_o, 0);
        expect_rsp(0, 1, 0);
        cyc_begin(); csr_set(1, 1, 200, D5, ALL);
        @(negedge clk_i);
        chk_gnt(1, 0);
        chk("oor_wr_mem_req", mem_req_o, 0);
        chk("oor_wr_mem_write", mem_write_o, 0);
        expect_rsp(0, 1, 0);
        cyc_begin(); ctl_set(1, 1, 128, D5, ALL, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        chk("oor128_mem_req", mem_req_o, 0);
        expect_rsp(1, 1, 0);
        cyc_begin(); ctl_set(1, 1, 127, D127, ALL, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        chk("wr127_mem_req", mem_req_o, 1);
        chk("wr127_mem_addr", 64'(mem_addr_o), 127);
        cyc_begin(); ctl_set(1, 0, 127, '0, '0, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        expect_rsp(1, 0, D127);
        cyc_begin();

        // Reset asserted the cycle after a controller read grant
        cyc_begin(); ctl_set(1, 0, 3, '0, '0, 0);
        @(negedge clk_i);
        chk_gnt(0, 1);
        cyc_begin();
        rst_ni = 1'b0;
        ctl_set(1, 1, 3, D3, ALL, 1);
        csr_set(1, 1, 5, D5, ALL);
        @(negedge clk_i);
        chk_reset_outputs();
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk_reset_outputs();
        cyc_begin();
        rst_ni = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            chk("post_rst_ctl_rvalid", ctl_rvalid_o, 0);
            cyc_begin();
        end

        @(negedge clk_i);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/dat_mem_arbiter.md
Name: dat_mem_arbiter

Overview:
Shares the single-port Device Address Table (DAT) RAM between two requesters. The first is the CSR/HCI software path (AHB register window into the DAT). The second is the controller command-execution path (device-address lookups and updates). It sits between those requesters and the prim_ram_1p_adv DAT instance, driving its req/write/addr/wdata/wmask and returning the 1-cycle-latency rdata to whichever requester owns the read. It provides a controller lock for atomic read-modify-write sequences, starvation protection for the CSR path, and out-of-range address rejection.

Parameters:
DEPTH, 128, DAT entries (matches DAT_DEPTH).
WIDTH, 64, entry width in bits.
AW, $clog2(DEPTH)+1, requester address width; one extra bit so out-of-range addresses are representable.
STARVE_LIMIT, 4, consecutive cycles a pending CSR request may lose before it is forced to win.
LOCK_MAX, 8, maximum cycles a controller lock may be held.

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
csr_req_i  in  1  CSR request; held stable until csr_gnt_o
csr_write_i  in  1  1=write, 0=read
csr_addr_i  in  AW  entry index
csr_wdata_i  in  WIDTH  write data
csr_wmask_i  in  WIDTH  bit write mask
csr_gnt_o  out  1  request accepted this cycle
csr_rvalid_o  out  1  read data/error valid
csr_rdata_o  out  WIDTH  read data
csr_err_o  out  1  out-of-range, qualified by rvalid/gnt
ctl_req_i, ctl_write_i, ctl_addr_i, ctl_wdata_i, ctl_wmask_i  in  1/1/AW/WIDTH/WIDTH  controller request, same rules as CSR
ctl_lock_i  in  1  hold ownership after current grant
ctl_gnt_o, ctl_rvalid_o, ctl_rdata_o, ctl_err_o  out  1/1/WIDTH/1  as CSR
lock_timeout_o  out  1  1-cycle pulse when lock forcibly released
mem_req_o  out  1  to RAM req_i
mem_write_o  out  1  to RAM write_i
mem_addr_o  out  $clog2(DEPTH)  to RAM addr_i
mem_wdata_o  out  WIDTH  to RAM wdata_i
mem_wmask_o  out  WIDTH  to RAM wmask_i
mem_rdata_i  in  WIDTH  from RAM rdata_o, valid 1 cycle after read req

Behaviour:
- Reset: all gnt/rvalid/err/mem_req/mem_write/lock_timeout = 0; rdata outputs 0; mem_addr/wdata/wmask 0. FSM = IDLE; starvation counter = 0; lock counter = 0; read-pending flag = 0.
- Grant is combinational in the request cycle. At most one gnt per cycle. mem_req_o = granted AND address in range.
- Address check: addr >= DEPTH gives gnt=1 with no RAM access. Next cycle: rvalid=1, err=1, rdata=0, for both reads and writes. In-range writes produce no rvalid.
- In-range read: the owner's rvalid_o=1 exactly one cycle after gnt, with rdata_o=mem_rdata_i and err=0. The owner is captured in a registered rd_owner_q. The non-owner's rdata_o is 0.
- Priority in IDLE: controller wins over CSR, unless the starvation counter equals STARVE_LIMIT, in which case CSR wins.
- Starvation counter: increments each cycle csr_req_i=1 and the CSR is not granted; clears on CSR grant or when csr_req_i=0; saturates at STARVE_LIMIT.
- FSM states:
  - IDLE: arbitrate. If the controller is granted with ctl_lock_i=1, go to LOCKED and clear the lock counter.
  - LOCKED: only the controller can be granted; CSR gnt=0 (starvation counter still counts but does not override). The lock counter increments every cycle.
  - LOCKED to IDLE when ctl_lock_i=0 (checked at the clock edge). The current-cycle controller grant, if any, is still honoured.
  - LOCKED to IDLE when the lock counter reaches LOCK_MAX-1: lock_timeout_o pulses 1 cycle, and ctl_lock_i is ignored until it drops to 0.
- Back-to-back: a new grant is allowed every cycle, including while a read response is being returned.
- Reset mid-read: the pending rvalid is discarded and no response is issued after reset.

Optional Feature:
I3C_DAT_ARB_RR_EN
- Defined: IDLE arbitration is round-robin. The last-granted requester loses on contention; the pointer resets to CSR-last, so the controller wins first. The starvation counter is removed and held at 0.
- Undefined: fixed controller-first priority with the starvation override described above.
- Lock behaviour is identical in both builds.

Test Plan:
- Single CSR write addr 5, wdata 0x1122_3344_5566_7788, full mask; then CSR read addr 5 -> gnt same cycle as req, mem_req_o=1; rvalid 1 cycle after read gnt with rdata 0x1122334455667788, err=0.
- Both requesters hold req every cycle (fixed priority) -> ctl granted 4 cycles, CSR granted on the 5th cycle (STARVE_LIMIT=4), then the pattern repeats. RR build: strict alternation starting with ctl.
- Controller read addr 3 with ctl_lock_i=1, write addr 3 next cycle, lock dropped -> CSR request pending throughout gets no gnt until the cycle after the lock drops; no lock_timeout_o.
- ctl_lock_i held for 20 cycles -> lock_timeout_o pulses once after 8 locked cycles; CSR granted next cycle; no relock until ctl_lock_i falls.
- CSR read addr 200 (DEPTH=128) -> gnt=1, mem_req_o=0; next cycle csr_rvalid_o=1, csr_err_o=1, rdata=0.
- rst_ni asserted the cycle after a ctl read gnt -> ctl_rvalid_o stays 0 and all outputs are at reset values while reset is held.
